// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ requesters.
// Optionally locks the grant for a whole packet and paces bytes on the transmitter's busy flag.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned LOCK_PKT      = 1,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_send,
  input  logic                       tx_sending,
  input  logic                       tx_ovf,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_start,
  output logic                       err_ovf
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(START_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(START_TIMEOUT - 1);
  localparam logic [IdW-1:0]  PtrInit = IdW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StWaitStart, StWaitDone} state_e;

  state_e          state_q;
  logic [IdW-1:0]  ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            last_q;

  logic [IdW-1:0]  winner;
  logic            any_valid;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  // Scan from the farthest offset down so the nearest valid index after ptr_q wins.
  always_comb begin
    logic [IdW-1:0] idx;
    winner    = ptr_q;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      idx = IdW'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (req_valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = req_data[{grant_id, 3'b000} +: 8];

  always_comb begin
    req_ready = '0;
    if (state_q == StXfer) req_ready[grant_id] = sel_valid;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= PtrInit;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      grant_id  <= '0;
      tx_data   <= 8'h00;
      tx_send   <= 1'b0;
      err_start <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      if (tx_ovf) err_ovf <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (any_valid && !tx_sending) begin
            grant_id <= winner;
            state_q  <= StXfer;
          end
        end
        StXfer: begin
          // A stalled requester keeps the grant; no other source can slip in mid-packet.
          if (sel_valid) begin
            tx_data <= sel_data;
            tx_send <= 1'b1;
            last_q  <= (LOCK_PKT == 0) ? 1'b1 : sel_last;
            cnt_q   <= '0;
            state_q <= StWaitStart;
          end
        end
        StWaitStart: begin
          if (tx_sending) begin
            state_q <= StWaitDone;
          end else if (cnt_q == CntLast) begin
            err_start <= 1'b1;
            ptr_q     <= grant_id;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitDone: begin
          if (!tx_sending) begin
            if (last_q) begin
              ptr_q   <= grant_id;
              state_q <= StIdle;
            end else begin
              state_q <= StXfer;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin vector table plus hand-written
// sequences for packet lock, start timeout, busy transmitter, overflow and async reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_sending;
  logic        tx_ovf = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_start;
  logic        err_ovf;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .LOCK_PKT     (1),
    .START_TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_sending(tx_sending),
    .tx_ovf    (tx_ovf),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_start (err_start),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Transmitter model: raises sending start_delay cycles after a send pulse, for hold_len cycles.
  bit   model_en = 1'b1;
  int   start_delay = 1;
  int   hold_len = 3;
  int   m_phase = 0;
  int   m_cnt = 0;
  logic m_sending = 1'b0;
  logic force_sending = 1'b0;
  int   send_cnt = 0;
  int   ready_cnt = 0;

  assign tx_sending = m_sending | force_sending;

  always @(negedge clk) begin
    if (tx_send) begin
      send_cnt++;
      check("send_while_sending", {31'd0, tx_sending}, 32'd0);
    end
    if (|req_ready) ready_cnt++;
    if (model_en) begin
      case (m_phase)
        0: if (tx_send) begin
          if (start_delay <= 1) begin
            m_sending = 1'b1; m_phase = 2; m_cnt = hold_len;
          end else begin
            m_phase = 1; m_cnt = start_delay - 1;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin m_sending = 1'b1; m_phase = 2; m_cnt = hold_len; end
        end
        default: begin
          m_cnt--;
          if (m_cnt == 0) begin m_sending = 1'b0; m_phase = 0; end
        end
      endcase
    end
  end

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_send) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sending(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (m_sending == lvl) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[14];
  bit   ok;
  int   s0, r0;

  initial begin
    vecs[0]  = '{4'b1111, 2'd0, 8'hA0};
    vecs[1]  = '{4'b1111, 2'd1, 8'hB1};
    vecs[2]  = '{4'b1111, 2'd2, 8'hC2};
    vecs[3]  = '{4'b1111, 2'd3, 8'hD3};
    vecs[4]  = '{4'b1111, 2'd0, 8'hA0};
    vecs[5]  = '{4'b1111, 2'd1, 8'hB1};
    vecs[6]  = '{4'b0001, 2'd0, 8'hA0};
    vecs[7]  = '{4'b1001, 2'd3, 8'hD3};
    vecs[8]  = '{4'b1001, 2'd0, 8'hA0};
    vecs[9]  = '{4'b0110, 2'd1, 8'hB1};
    vecs[10] = '{4'b0110, 2'd2, 8'hC2};
    vecs[11] = '{4'b0100, 2'd2, 8'hC2};
    vecs[12] = '{4'b1010, 2'd3, 8'hD3};
    vecs[13] = '{4'b1010, 2'd1, 8'hB1};

    #1 rst_n = 1'b0;
    req_data = 32'hD3C2B1A0;
    req_last = 4'b1111;
    #3;
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_start", {31'd0, err_start}, 32'd0);
    check("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin table, single-byte packets.
    for (int v = 0; v < 14; v++) begin
      s0 = send_cnt;
      r0 = ready_cnt;
      req_valid = vecs[v].valid;
      wait_send(ok);
      check($sformatf("rr%0d_send_seen", v), {31'd0, ok}, 32'd1);
      check($sformatf("rr%0d_grant", v), {30'd0, grant_id}, {30'd0, vecs[v].exp_grant});
      check($sformatf("rr%0d_data", v), {24'd0, tx_data}, {24'd0, vecs[v].exp_data});
      wait_idle(ok);
      check($sformatf("rr%0d_idle", v), {31'd0, ok}, 32'd1);
      check($sformatf("rr%0d_sends", v), send_cnt - s0, 32'd1);
      check($sformatf("rr%0d_readys", v), ready_cnt - r0, 32'd1);
    end
    req_valid = '0;

    // Single requester, slow transmitter.
    start_delay = 2;
    hold_len = 20;
    req_data[23:16] = 8'hA5;
    s0 = send_cnt;
    r0 = ready_cnt;
    req_valid = 4'b0100;
    wait_send(ok);
    req_valid = '0;
    check("single_send_seen", {31'd0, ok}, 32'd1);
    check("single_grant", {30'd0, grant_id}, 32'd2);
    check("single_data", {24'd0, tx_data}, 32'hA5);
    wait_sending(1'b1, ok);
    check("single_busy_sending", {31'd0, busy}, 32'd1);
    wait_sending(1'b0, ok);
    check("single_busy_at_fall", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("single_idle_after", {31'd0, busy}, 32'd0);
    check("single_sends", send_cnt - s0, 32'd1);
    check("single_readys", ready_cnt - r0, 32'd1);

    // Move the pointer to requester 0.
    hold_len = 3;
    req_data[7:0] = 8'h55;
    req_valid = 4'b0001;
    wait_send(ok);
    req_valid = '0;
    check("pre_lock_grant", {30'd0, grant_id}, 32'd0);
    wait_idle(ok);

    // Packet lock: requester 1 sends 0x11,0x22,0x33 while requester 0 waits.
    req_data[15:8] = 8'h11;
    req_last = 4'b0001;
    req_valid = 4'b0011;
    wait_send(ok);
    check("lock_b0_grant", {30'd0, grant_id}, 32'd1);
    check("lock_b0_data", {24'd0, tx_data}, 32'h11);
    req_valid[1] = 1'b0;
    req_data[15:8] = 8'h22;
    wait_sending(1'b1, ok);
    wait_sending(1'b0, ok);
    s0 = send_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("lock_stall%0d_grant", k), {30'd0, grant_id}, 32'd1);
    end
    check("lock_stall_busy", {31'd0, busy}, 32'd1);
    check("lock_stall_no_send", send_cnt - s0, 32'd0);
    req_valid[1] = 1'b1;
    wait_send(ok);
    check("lock_b1_grant", {30'd0, grant_id}, 32'd1);
    check("lock_b1_data", {24'd0, tx_data}, 32'h22);
    req_data[15:8] = 8'h33;
    req_last[1] = 1'b1;
    wait_send(ok);
    check("lock_b2_grant", {30'd0, grant_id}, 32'd1);
    check("lock_b2_data", {24'd0, tx_data}, 32'h33);
    req_valid[1] = 1'b0;
    wait_send(ok);
    check("lock_after_grant", {30'd0, grant_id}, 32'd0);
    check("lock_after_data", {24'd0, tx_data}, 32'h55);
    req_valid = '0;
    wait_idle(ok);

    // Start timeout: transmitter never starts.
    model_en = 1'b0;
    req_data[31:24] = 8'h3C;
    req_last = 4'b1111;
    req_valid = 4'b1000;
    wait_send(ok);
    check("to_grant", {30'd0, grant_id}, 32'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) check("to_err_early", {31'd0, err_start}, 32'd0);
      if (k == 4) begin
        check("to_err_set", {31'd0, err_start}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
      end
    end
    model_en = 1'b1;
    wait_send(ok);
    check("to_regrant_seen", {31'd0, ok}, 32'd1);
    check("to_regrant_grant", {30'd0, grant_id}, 32'd3);
    check("to_regrant_data", {24'd0, tx_data}, 32'h3C);
    req_valid = '0;
    wait_idle(ok);
    check("to_err_sticky", {31'd0, err_start}, 32'd1);

    // Transmitter busy when a request appears.
    force_sending = 1'b1;
    req_data[7:0] = 8'h5A;
    s0 = send_cnt;
    req_valid = 4'b0001;
    repeat (6) @(negedge clk);
    check("busytx_no_grant", {31'd0, busy}, 32'd0);
    check("busytx_no_send", send_cnt - s0, 32'd0);
    force_sending = 1'b0;
    wait_send(ok);
    check("busytx_grant", {30'd0, grant_id}, 32'd0);
    check("busytx_data", {24'd0, tx_data}, 32'h5A);
    req_valid = '0;
    wait_idle(ok);

    // Overflow flag is sticky.
    @(negedge clk);
    tx_ovf = 1'b1;
    @(negedge clk);
    tx_ovf = 1'b0;
    check("ovf_set", {31'd0, err_ovf}, 32'd1);
    repeat (3) @(negedge clk);
    check("ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // Asynchronous reset while waiting for the transmitter to finish.
    hold_len = 20;
    req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    wait_send(ok);
    check("rstw_data", {24'd0, tx_data}, 32'h77);
    wait_sending(1'b1, ok);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_tx_data", {24'd0, tx_data}, 32'h00);
    check("rstw_tx_send", {31'd0, tx_send}, 32'd0);
    check("rstw_req_ready", {28'd0, req_ready}, 32'd0);
    check("rstw_grant_id", {30'd0, grant_id}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_err_start", {31'd0, err_start}, 32'd0);
    check("rstw_err_ovf", {31'd0, err_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = send_cnt;
    repeat (2) @(negedge clk);
    check("rstw_hold_off", {31'd0, busy}, 32'd0);
    check("rstw_no_send", send_cnt - s0, 32'd0);
    wait_send(ok);
    check("rstw_regrant_seen", {31'd0, ok}, 32'd1);
    check("rstw_regrant_grant", {30'd0, grant_id}, 32'd1);
    req_valid = '0;
    wait_idle(ok);
    check("final_idle", {31'd0, ok}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
